// File: rtl/clks_alot_lock_ctrl.sv
// Lock/pause controller for the clock-recovery path: tracks in-band rate
// samples and recovered edges, and runs the acquire/lock/drift/pause FSM.
module clks_alot_lock_ctrl #(
    parameter int RATE_COUNTER_WIDTH  = 32,
    parameter int DRIFT_COUNTER_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic                          pausable_i,
    input  logic                          even_50_50_en_i,
    input  logic                          any_valid_edge_i,
    input  logic                          rate_valid_i,
    input  logic                          rate_is_high_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] rate_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] high_min_m1_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] high_max_m1_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] low_min_m1_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] low_max_m1_i,
    input  logic [RATE_COUNTER_WIDTH-1:0] pause_threshold_i,
    input  logic [DRIFT_COUNTER_WIDTH-1:0] acquire_count_i,
    input  logic [DRIFT_COUNTER_WIDTH-1:0] drift_limit_i,
    output logic                          locked_o,
    output logic                          pause_active_o,
    output logic [RATE_COUNTER_WIDTH-1:0] pause_duration_o,
    output logic                          out_of_band_o,
    output logic                          lost_lock_o,
    output logic                          pause_violation_o,
    output logic [1:0]                    state_o
);

    localparam int RW = RATE_COUNTER_WIDTH;
    localparam int DW = DRIFT_COUNTER_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_PAUSED = 2'd3;

    localparam logic [RW-1:0] RONE = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DONE = {{(DW-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] acq_q, acq_d;
    logic [DW-1:0] drift_q, drift_d;
    logic [RW-1:0] idle_q, idle_d;
    logic [RW-1:0] sub_q, sub_d;
    logic [RW-1:0] pdur_q, pdur_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [RW-1:0] last_hi_q, last_hi_d;
    logic [RW-1:0] last_lo_q, last_lo_d;
    logic          oob_q, oob_d;
    logic          lost_q, lost_d;
    logic          viol_q, viol_d;

    logic          use_hi;
    logic [RW-1:0] min_m1;
    logic [RW-1:0] max_m1;
    logic [RW:0]   max_p1;
    logic          in_band;
    logic [DW-1:0] acq_inc;
    logic [DW-1:0] drift_inc;
    logic [DW-1:0] drift_dec;
    logic [RW-1:0] idle_inc;
    logic [RW-1:0] pdur_inc;
    logic [RW-1:0] sub_lim;
    logic          sub_wrap;
    logic [RW-1:0] ref_new;

    // Band compare is one bit wider so max_m1 = all-ones cannot wrap
    assign use_hi  = even_50_50_en_i | rate_is_high_i;
    assign min_m1  = use_hi ? high_min_m1_i : low_min_m1_i;
    assign max_m1  = use_hi ? high_max_m1_i : low_max_m1_i;
    assign max_p1  = {1'b0, max_m1} + {{RW{1'b0}}, 1'b1};
    assign in_band = ({1'b0, rate_i} > {1'b0, min_m1}) &&
                     ({1'b0, rate_i} <= max_p1);

    assign acq_inc   = (&acq_q) ? acq_q : acq_q + DONE;
    assign drift_inc = (&drift_q) ? drift_q : drift_q + DONE;
    assign drift_dec = (drift_q == '0) ? '0 : drift_q - DONE;
    assign idle_inc  = (&idle_q) ? idle_q : idle_q + RONE;
    assign pdur_inc  = (&pdur_q) ? pdur_q : pdur_q + RONE;
    assign sub_lim   = (ref_q == '0) ? '0 : ref_q - RONE;
    assign sub_wrap  = (sub_q >= sub_lim);
    assign ref_new   = even_50_50_en_i ? rate_i + rate_i :
                       rate_i + (rate_is_high_i ? last_lo_q : last_hi_q);

    always_comb begin
        state_d   = state_q;
        acq_d     = acq_q;
        drift_d   = drift_q;
        idle_d    = idle_q;
        sub_d     = sub_q;
        pdur_d    = pdur_q;
        ref_d     = ref_q;
        last_hi_d = last_hi_q;
        last_lo_d = last_lo_q;
        oob_d     = 1'b0;
        lost_d    = 1'b0;
        viol_d    = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            acq_d   = '0;
            drift_d = '0;
            idle_d  = '0;
            sub_d   = '0;
            pdur_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    acq_d   = '0;
                end
                ST_ACQ: begin
                    if (rate_valid_i) begin
                        if (in_band) begin
                            if (use_hi) last_hi_d = rate_i;
                            else        last_lo_d = rate_i;
                            if (acq_inc >= acquire_count_i) begin
                                state_d = ST_LOCKED;
                                drift_d = '0;
                                idle_d  = '0;
                            end else begin
                                acq_d = acq_inc;
                            end
                        end else begin
                            acq_d = '0;
                            oob_d = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    idle_d = any_valid_edge_i ? '0 : idle_inc;
                    if (rate_valid_i) begin
                        if (in_band) begin
                            drift_d = drift_dec;
                            ref_d   = ref_new;
                            if (use_hi) last_hi_d = rate_i;
                            else        last_lo_d = rate_i;
                        end else begin
                            drift_d = drift_inc;
                            oob_d   = 1'b1;
                        end
                    end
                    // A sample or edge in the timeout cycle suppresses the timeout
                    if (!any_valid_edge_i && !rate_valid_i &&
                        idle_d >= pause_threshold_i) begin
                        if (pausable_i) begin
                            state_d = ST_PAUSED;
                            pdur_d  = '0;
                            sub_d   = '0;
                        end else begin
                            state_d = ST_ACQ;
                            acq_d   = '0;
                            viol_d  = 1'b1;
                            lost_d  = 1'b1;
                        end
                    end else if (drift_limit_i != '0 &&
                                 drift_d >= drift_limit_i) begin
                        state_d = ST_ACQ;
                        acq_d   = '0;
                        lost_d  = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    idle_d = any_valid_edge_i ? '0 : idle_inc;
                    if (sub_wrap) begin
                        sub_d  = '0;
                        pdur_d = pdur_inc;
                    end else begin
                        sub_d = sub_q + RONE;
                    end
                    if (any_valid_edge_i) state_d = ST_LOCKED;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            acq_q     <= '0;
            drift_q   <= '0;
            idle_q    <= '0;
            sub_q     <= '0;
            pdur_q    <= '0;
            ref_q     <= '0;
            last_hi_q <= '0;
            last_lo_q <= '0;
            oob_q     <= 1'b0;
            lost_q    <= 1'b0;
            viol_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acq_q     <= acq_d;
            drift_q   <= drift_d;
            idle_q    <= idle_d;
            sub_q     <= sub_d;
            pdur_q    <= pdur_d;
            ref_q     <= ref_d;
            last_hi_q <= last_hi_d;
            last_lo_q <= last_lo_d;
            oob_q     <= oob_d;
            lost_q    <= lost_d;
            viol_q    <= viol_d;
        end
    end

    assign state_o           = state_q;
    assign locked_o          = state_q[1];
    assign pause_active_o    = (state_q == ST_PAUSED);
    assign pause_duration_o  = pdur_q;
    assign out_of_band_o     = oob_q;
    assign lost_lock_o       = lost_q;
    assign pause_violation_o = viol_q;

endmodule

// File: tb/tb_clks_alot_lock_ctrl.sv
// Bench for clks_alot_lock_ctrl: directed plan steps, then random traffic
// checked every cycle against a cycle-count based reference model.
module tb_clks_alot_lock_ctrl;

    localparam int RW = 32;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, enable, pausable, even, edge_ev, rv, is_high;
    logic [RW-1:0] rate, hmin, hmax, lmin, lmax, thr;
    logic [DW-1:0] acq_n, drift_lim;
    logic          locked, pause_act, oob, lost, viol;
    logic [RW-1:0] dur;
    logic [1:0]    st;

    clks_alot_lock_ctrl #(
        .RATE_COUNTER_WIDTH (RW),
        .DRIFT_COUNTER_WIDTH(DW)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .enable_i         (enable),
        .pausable_i       (pausable),
        .even_50_50_en_i  (even),
        .any_valid_edge_i (edge_ev),
        .rate_valid_i     (rv),
        .rate_is_high_i   (is_high),
        .rate_i           (rate),
        .high_min_m1_i    (hmin),
        .high_max_m1_i    (hmax),
        .low_min_m1_i     (lmin),
        .low_max_m1_i     (lmax),
        .pause_threshold_i(thr),
        .acquire_count_i  (acq_n),
        .drift_limit_i    (drift_lim),
        .locked_o         (locked),
        .pause_active_o   (pause_act),
        .pause_duration_o (dur),
        .out_of_band_o    (oob),
        .lost_lock_o      (lost),
        .pause_violation_o(viol),
        .state_o          (st)
    );

    // Reference model: states 0..3, gap = cycles since last edge,
    // pause duration = paused cycles divided by the reference period.
    int              m_state, m_acq, m_drift;
    longint unsigned m_gap, m_pcyc;
    logic [RW-1:0]   m_ref, m_dur;
    logic [RW-1:0]   m_last [2];
    bit              m_oob, m_lost, m_viol;

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_acq = 0; m_drift = 0;
        m_gap = 0; m_pcyc = 0; m_ref = '0; m_dur = '0;
        m_last[0] = '0; m_last[1] = '0;
        m_oob = 0; m_lost = 0; m_viol = 0;
    endtask

    task automatic model_step();
        bit hi, inb;
        longint unsigned mn, mx, r, per, q;
        hi  = even || is_high;
        mn  = hi ? hmin : lmin;
        mx  = hi ? hmax : lmax;
        r   = rate;
        inb = (r > mn) && (r <= mx + 1);
        m_oob = 0; m_lost = 0; m_viol = 0;
        if (!enable) begin
            m_state = 0; m_acq = 0; m_drift = 0;
            m_gap = 0; m_pcyc = 0; m_dur = '0;
            return;
        end
        case (m_state)
            0: begin
                m_state = 1;
                m_acq = 0;
            end
            1: if (rv) begin
                if (inb) begin
                    m_last[hi] = rate;
                    m_acq++;
                    if (m_acq >= int'(acq_n)) begin
                        m_state = 2; m_drift = 0; m_gap = 0;
                    end
                end else begin
                    m_acq = 0; m_oob = 1;
                end
            end
            2: begin
                m_gap = edge_ev ? 0 : m_gap + 1;
                if (rv) begin
                    if (inb) begin
                        m_drift = (m_drift > 0) ? m_drift - 1 : 0;
                        m_ref = even ? RW'(2 * r) : RW'(r + m_last[!hi]);
                        m_last[hi] = rate;
                    end else begin
                        m_drift = (m_drift < 255) ? m_drift + 1 : 255;
                        m_oob = 1;
                    end
                end
                if (!edge_ev && !rv && m_gap >= thr) begin
                    if (pausable) begin
                        m_state = 3; m_pcyc = 0; m_dur = '0;
                    end else begin
                        m_state = 1; m_acq = 0; m_lost = 1; m_viol = 1;
                    end
                end else if (drift_lim != 0 && m_drift >= int'(drift_lim)) begin
                    m_state = 1; m_acq = 0; m_lost = 1;
                end
            end
            default: begin
                per = (m_ref == 0) ? 1 : m_ref;
                m_pcyc++;
                q = m_pcyc / per;
                m_dur = (q > 64'hFFFF_FFFF) ? '1 : RW'(q);
                if (edge_ev) begin
                    m_state = 2; m_gap = 0;
                end else begin
                    m_gap++;
                end
            end
        endcase
    endtask

    task automatic check_all(string tag);
        chk({tag, ":state"},  64'(st),        64'(m_state));
        chk({tag, ":locked"}, 64'(locked),    64'(m_state >= 2));
        chk({tag, ":pause"},  64'(pause_act), 64'(m_state == 3));
        chk({tag, ":dur"},    64'(dur),       64'(m_dur));
        chk({tag, ":oob"},    64'(oob),       64'(m_oob));
        chk({tag, ":lost"},   64'(lost),      64'(m_lost));
        chk({tag, ":viol"},   64'(viol),      64'(m_viol));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        rv = 1'b0;
        edge_ev = 1'b0;
    endtask

    task automatic smp(logic [RW-1:0] r, logic h, string tag);
        rate = r; is_high = h; rv = 1'b1; edge_ev = 1'b1;
        tick(tag);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pausable = 1'b1; even = 1'b0;
        edge_ev = 1'b0; rv = 1'b0; is_high = 1'b0; rate = '0;
        hmin = 8; hmax = 10; lmin = 8; lmax = 10;
        thr = 50; acq_n = 4; drift_lim = 3;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_state", 64'(st), 0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick("idle2acq");
        chk("acq_state", 64'(st), 1);

        // Lock after four in-band samples
        for (int i = 0; i < 3; i++) smp(10, 1'(i % 2), "acq");
        chk("not_yet_locked", 64'(locked), 0);
        smp(10, 1'b1, "acq4");
        chk("lock_state", 64'(st), 2);
        chk("lock_locked", 64'(locked), 1);

        // Drift 1,0,1,2 then break lock
        smp(13, 1'b0, "d1");
        smp(10, 1'b1, "d0");
        smp(13, 1'b0, "d1b");
        smp(13, 1'b1, "d2");
        chk("drift_hold", 64'(st), 2);
        smp(13, 1'b0, "d3");
        chk("drift_state", 64'(st), 1);
        chk("drift_lost", 64'(lost), 1);
        chk("drift_unlocked", 64'(locked), 0);
        tick("drift_after");
        chk("drift_lost_pulse", 64'(lost), 0);

        // Acquire restart on an out-of-band sample
        smp(10, 1'b0, "ar1");
        smp(10, 1'b1, "ar2");
        smp(13, 1'b0, "ar3");
        chk("ar_oob", 64'(oob), 1);
        smp(10, 1'b1, "ar4");
        chk("ar_not_locked", 64'(st), 1);
        chk("ar_oob_once", 64'(oob), 0);
        smp(10, 1'b0, "ar5");
        smp(10, 1'b1, "ar6");
        smp(10, 1'b0, "ar7");
        chk("ar_locked", 64'(st), 2);

        // Pausable pause with ref_period 20
        smp(10, 1'b1, "ref20");
        for (int k = 1; k < 250; k++) begin
            tick("gap");
            if (k == 49) chk("pause_not_yet", 64'(pause_act), 0);
            if (k == 50) chk("pause_rise", 64'(pause_act), 1);
        end
        edge_ev = 1'b1;
        tick("resume");
        chk("resume_dur", 64'(dur), 10);
        chk("resume_state", 64'(st), 2);

        // Continuous mode: edge exactly at the threshold, then a real gap
        pausable = 1'b0;
        smp(10, 1'b0, "cont0");
        for (int k = 1; k < 50; k++) tick("cgap");
        edge_ev = 1'b1;
        tick("cedge50");
        chk("cont_no_viol", 64'(viol), 0);
        chk("cont_still_locked", 64'(st), 2);
        for (int k = 1; k <= 50; k++) tick("cgap2");
        chk("cont_viol", 64'(viol), 1);
        chk("cont_lost", 64'(lost), 1);
        chk("cont_state", 64'(st), 1);

        // Async reset in the middle of a pause
        pausable = 1'b1;
        for (int i = 0; i < 4; i++) smp(10, 1'(i % 2), "relock");
        for (int k = 0; k < 60; k++) tick("pgap");
        chk("pre_rst_pause", 64'(pause_act), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_state", 64'(st), 0);
        chk("arst_locked", 64'(locked), 0);
        chk("arst_pause", 64'(pause_act), 0);
        chk("arst_dur", 64'(dur), 0);
        check_all("arst");
        #2;
        rst_n = 1'b1;
        tick("post_rst");
        chk("post_rst_state", 64'(st), 1);

        // Enable drop while locked after a pause
        for (int i = 0; i < 4; i++) smp(10, 1'(i % 2), "relock2");
        for (int k = 0; k < 80; k++) tick("pgap2");
        edge_ev = 1'b1;
        tick("resume2");
        chk("resume2_locked", 64'(st), 2);
        enable = 1'b0;
        tick("en_drop");
        chk("en_drop_state", 64'(st), 0);
        chk("en_drop_dur", 64'(dur), 0);

        // max_m1 all-ones must not wrap
        enable = 1'b1;
        tick("en_up");
        hmax = '1; acq_n = 1;
        smp(32'hFFFF_FFFF, 1'b1, "maxband");
        chk("maxband_oob", 64'(oob), 0);
        chk("maxband_lock", 64'(st), 2);
        hmax = 10;

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                hmin = $urandom_range(4, 10);
                hmax = hmin + $urandom_range(0, 4);
                lmin = $urandom_range(4, 10);
                lmax = lmin + $urandom_range(0, 4);
                thr = $urandom_range(0, 40);
                acq_n = DW'($urandom_range(0, 5));
                drift_lim = DW'($urandom_range(0, 4));
                pausable = 1'($urandom_range(0, 1));
                even = ($urandom_range(0, 3) == 0);
            end
            enable = ($urandom_range(0, 63) != 0);
            rv = ($urandom_range(0, 2) == 0);
            is_high = 1'($urandom_range(0, 1));
            rate = $urandom_range(3, 16);
            edge_ev = rv ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            if ((cyc / 100) % 3 == 2) begin
                rv = 1'b0;
                edge_ev = ($urandom_range(0, 79) == 0);
            end
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
